// File: rtl/serdes_lane_ctrl_pkg.sv
// Shared types for the SERDES lane bring-up controller.
package serdes_lane_ctrl_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_PLL,
    ST_PMA_SETTLE,
    ST_WAIT_CDR,
    ST_PCS_SETTLE,
    ST_READY
  } lane_state_e;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/serdes_lane_seq.sv
// One lane's input synchronizers, reset-sequencing FSM, settle/timeout timer
// and saturating retry counter.
//   state         | meaning
//   ST_RESET      | PMA and PCS held in reset for one cycle
//   ST_WAIT_PLL   | waiting for CMU lock
//   ST_PMA_SETTLE | PMA released, settle timer running
//   ST_WAIT_CDR   | waiting for CDR lock + signal detect, timeout running
//   ST_PCS_SETTLE | PCS released, settle timer running
//   ST_READY      | lane usable
module serdes_lane_seq
  import serdes_lane_ctrl_pkg::*;
#(
  parameter int SETTLE    = 64,
  parameter int LOCK_WAIT = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pll_lock_i,
  input  logic               cdr_lock_i,
  input  logic               sig_det_i,
  output logic               pma_rstn_o,
  output logic               pcs_rst_o,
  output logic               lane_ready_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam int CNT_W = $clog2(LOCK_WAIT + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_WAIT - 1);

  logic [1:0]         pll_sync_q, cdr_sync_q, sig_sync_q;
  lane_state_e        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pma_rstn_q, pcs_rst_q, ready_q;
  logic [RETRY_W-1:0] retry_q;
  logic               pll_ok, link_ok, pll_lost, link_lost, cdr_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pll_sync_q <= '0;
      cdr_sync_q <= '0;
      sig_sync_q <= '0;
    end else begin
      pll_sync_q <= {pll_sync_q[0], pll_lock_i};
      cdr_sync_q <= {cdr_sync_q[0], cdr_lock_i};
      sig_sync_q <= {sig_sync_q[0], sig_det_i};
    end
  end

  assign pll_ok  = pll_sync_q[1];
  assign link_ok = cdr_sync_q[1] & sig_sync_q[1];

  // Lock loss is evaluated ahead of any timer completion so it always wins.
  assign pll_lost    = !pll_ok && (state_q inside {ST_PMA_SETTLE, ST_WAIT_CDR,
                                                   ST_PCS_SETTLE, ST_READY});
  assign link_lost   = !link_ok && (state_q inside {ST_PCS_SETTLE, ST_READY});
  assign cdr_timeout = !link_ok && (state_q == ST_WAIT_CDR) && (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      pma_rstn_q <= 1'b0;
      pcs_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      retry_q    <= '0;
    end else if (pll_lost || link_lost || cdr_timeout) begin
      state_q    <= ST_RESET;
      pma_rstn_q <= 1'b0;
      pcs_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      if (!pll_lost) retry_q <= sat_inc(retry_q);
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_WAIT_PLL;
        ST_WAIT_PLL:
          if (pll_ok) begin
            state_q    <= ST_PMA_SETTLE;
            pma_rstn_q <= 1'b1;
            cnt_q      <= SETTLE_LD;
          end
        ST_PMA_SETTLE:
          if (cnt_q == '0) begin
            state_q <= ST_WAIT_CDR;
            cnt_q   <= LOCK_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        ST_WAIT_CDR:
          if (link_ok) begin
            state_q   <= ST_PCS_SETTLE;
            pcs_rst_q <= 1'b0;
            cnt_q     <= SETTLE_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        ST_PCS_SETTLE:
          if (cnt_q == '0) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        ST_READY: state_q <= ST_READY;
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign pma_rstn_o   = pma_rstn_q;
  assign pcs_rst_o    = pcs_rst_q;
  assign lane_ready_o = ready_q;
  assign retry_cnt_o  = retry_q;

endmodule

// File: rtl/serdes_lane_ctrl.sv
// N-lane SERDES bring-up controller: per-lane sequencers plus readiness gating
// of the PHY TX/RX interface-FIFO handshakes.
module serdes_lane_ctrl
  import serdes_lane_ctrl_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int TXD_W     = 80,
  parameter int RXD_W     = 88,
  parameter int SETTLE    = 64,
  parameter int LOCK_WAIT = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [LANES-1:0]       pll_lock_i,
  input  logic [LANES-1:0]       cdr_lock_i,
  input  logic [LANES-1:0]       sig_det_i,
  output logic [LANES-1:0]       pma_rstn_o,
  output logic [LANES-1:0]       pcs_rx_rst_o,
  output logic [LANES-1:0]       pcs_tx_rst_o,
  output logic [LANES-1:0]       lane_ready_o,
  output logic [4*LANES-1:0]     retry_cnt_o,
  input  logic [LANES*TXD_W-1:0] tx_data_i,
  input  logic [LANES-1:0]       tx_valid_i,
  output logic [LANES-1:0]       tx_ready_o,
  output logic [LANES*TXD_W-1:0] phy_tx_data_o,
  output logic [LANES-1:0]       phy_tx_wren_o,
  input  logic [LANES-1:0]       phy_tx_afull_i,
  input  logic [LANES*RXD_W-1:0] phy_rx_data_i,
  input  logic [LANES-1:0]       phy_rx_vld_i,
  input  logic [LANES-1:0]       phy_rx_empty_i,
  output logic [LANES-1:0]       phy_rx_rden_o,
  output logic [LANES*RXD_W-1:0] rx_data_o,
  output logic [LANES-1:0]       rx_valid_o
);

  logic [LANES-1:0]       pcs_rst, ready;
  logic [LANES*RXD_W-1:0] rx_data_q;
  logic [LANES-1:0]       rx_valid_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    serdes_lane_seq #(
      .SETTLE    (SETTLE),
      .LOCK_WAIT (LOCK_WAIT)
    ) u_seq (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pll_lock_i   (pll_lock_i[l]),
      .cdr_lock_i   (cdr_lock_i[l]),
      .sig_det_i    (sig_det_i[l]),
      .pma_rstn_o   (pma_rstn_o[l]),
      .pcs_rst_o    (pcs_rst[l]),
      .lane_ready_o (ready[l]),
      .retry_cnt_o  (retry_cnt_o[l*RETRY_W +: RETRY_W])
    );
  end

  assign pcs_rx_rst_o = pcs_rst;
  assign pcs_tx_rst_o = pcs_rst;
  assign lane_ready_o = ready;

  assign tx_ready_o    = ready & ~phy_tx_afull_i;
  assign phy_tx_wren_o = tx_valid_i & tx_ready_o;
  assign phy_tx_data_o = tx_data_i;

  assign phy_rx_rden_o = ready & ~phy_rx_empty_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_q  <= '0;
      rx_valid_q <= '0;
    end else begin
      rx_data_q  <= phy_rx_data_i;
      rx_valid_q <= phy_rx_vld_i & ready;
    end
  end

  // Gating again on the output blanks the word captured on the edge ready fell.
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q & ready;

endmodule

// File: tb/tb_serdes_lane_ctrl.sv
// Scoreboard bench for serdes_lane_ctrl with two lanes and short timers.
module tb_serdes_lane_ctrl;

  localparam int LANES = 2, TXD_W = 8, RXD_W = 8, SETTLE = 4, LOCK_WAIT = 16;

  logic                   clk_i = 1'b0, rst_i = 1'b1;
  logic [LANES-1:0]       pll_lock_i, cdr_lock_i, sig_det_i;
  logic [LANES-1:0]       pma_rstn_o, pcs_rx_rst_o, pcs_tx_rst_o, lane_ready_o;
  logic [4*LANES-1:0]     retry_cnt_o;
  logic [LANES*TXD_W-1:0] tx_data_i, phy_tx_data_o;
  logic [LANES-1:0]       tx_valid_i, tx_ready_o, phy_tx_wren_o, phy_tx_afull_i;
  logic [LANES*RXD_W-1:0] phy_rx_data_i, rx_data_o;
  logic [LANES-1:0]       phy_rx_vld_i, phy_rx_empty_i, phy_rx_rden_o, rx_valid_o;

  serdes_lane_ctrl #(
    .LANES(LANES), .TXD_W(TXD_W), .RXD_W(RXD_W), .SETTLE(SETTLE), .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pll_lock_i(pll_lock_i), .cdr_lock_i(cdr_lock_i), .sig_det_i(sig_det_i),
    .pma_rstn_o(pma_rstn_o), .pcs_rx_rst_o(pcs_rx_rst_o), .pcs_tx_rst_o(pcs_tx_rst_o),
    .lane_ready_o(lane_ready_o), .retry_cnt_o(retry_cnt_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .phy_tx_data_o(phy_tx_data_o), .phy_tx_wren_o(phy_tx_wren_o),
    .phy_tx_afull_i(phy_tx_afull_i),
    .phy_rx_data_i(phy_rx_data_i), .phy_rx_vld_i(phy_rx_vld_i),
    .phy_rx_empty_i(phy_rx_empty_i), .phy_rx_rden_o(phy_rx_rden_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic val;
    int   cyc;
  } ev_t;

  ev_t        rdy_q[$], pma_q[$];
  logic [7:0] tx_q[$], rx_q[$];
  logic [3:0] ret_q[$];
  bit         edge_mon_en = 1'b1;

  logic       prev_rdy = 1'b0, prev_pma = 1'b0;
  logic [3:0] prev_ret = 4'd0;

  // Monitor: pops expectations whenever lane 0 shows an output event.
  always @(negedge clk_i) begin
    ev_t e;
    if (!rst_i) begin
      if (phy_tx_wren_o[0]) begin
        if (tx_q.size() == 0) check("tx0_wren_unexpected", phy_tx_wren_o[0], 1'b0);
        else check("tx0_data", phy_tx_data_o[7:0], tx_q.pop_front());
      end
      if (rx_valid_o[0]) begin
        if (rx_q.size() == 0) check("rx0_valid_unexpected", rx_valid_o[0], 1'b0);
        else check("rx0_data", rx_data_o[7:0], rx_q.pop_front());
      end
      check("tx1_wren_idle", phy_tx_wren_o[1], 1'b0);
      check("rx1_valid_idle", rx_valid_o[1], 1'b0);
      if (edge_mon_en && lane_ready_o[0] !== prev_rdy) begin
        if (rdy_q.size() == 0) check("rdy0_unexpected_edge", lane_ready_o[0], prev_rdy);
        else begin
          e = rdy_q.pop_front();
          check("rdy0_level", lane_ready_o[0], e.val);
          check("rdy0_cycle", cyc, e.cyc);
        end
      end
      if (edge_mon_en && pma_rstn_o[0] !== prev_pma) begin
        if (pma_q.size() == 0) check("pma0_unexpected_edge", pma_rstn_o[0], prev_pma);
        else begin
          e = pma_q.pop_front();
          check("pma0_level", pma_rstn_o[0], e.val);
          check("pma0_cycle", cyc, e.cyc);
        end
      end
      if (retry_cnt_o[3:0] !== prev_ret) begin
        if (ret_q.size() == 0) check("retry0_unexpected", retry_cnt_o[3:0], prev_ret);
        else check("retry0_value", retry_cnt_o[3:0], ret_q.pop_front());
      end
    end
    prev_rdy = lane_ready_o[0];
    prev_pma = pma_rstn_o[0];
    prev_ret = retry_cnt_o[3:0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int c;
    logic [5:0] afull_pat;
    afull_pat      = 6'b010010;
    pll_lock_i     = '0;
    cdr_lock_i     = '0;
    sig_det_i      = '0;
    tx_valid_i     = 2'b11;
    tx_data_i      = 16'h2211;
    phy_tx_afull_i = '0;
    phy_rx_data_i  = 16'h5AA5;
    phy_rx_vld_i   = 2'b11;
    phy_rx_empty_i = 2'b00;

    tick(3);
    @(negedge clk_i);
    check("rst_pma_rstn", pma_rstn_o, 2'b00);
    check("rst_pcs_rx", pcs_rx_rst_o, 2'b11);
    check("rst_pcs_tx", pcs_tx_rst_o, 2'b11);
    check("rst_ready", lane_ready_o, 2'b00);
    check("rst_retry", retry_cnt_o, 8'h00);
    check("rst_tx_ready", tx_ready_o, 2'b00);
    check("rst_wren", phy_tx_wren_o, 2'b00);
    check("rst_rden", phy_rx_rden_o, 2'b00);
    check("rst_rx_valid", rx_valid_o, 2'b00);
    check("rst_rx_data", rx_data_o, 16'h0000);

    @(posedge clk_i); #1;
    rst_i          = 1'b0;
    tx_valid_i     = 2'b10;
    phy_rx_vld_i   = 2'b10;
    phy_rx_empty_i = 2'b01;
    tick(2);

    // Lane 0 bring-up; lane 1 has no PLL lock and must stay parked.
    c = cyc;
    pll_lock_i[0] = 1'b1;
    sig_det_i[0]  = 1'b1;
    pma_q.push_back('{1'b1, c + 3});
    tick(10);
    c = cyc;
    cdr_lock_i[0] = 1'b1;
    rdy_q.push_back('{1'b1, c + 2 + 1 + SETTLE});
    tick(9);
    @(negedge clk_i);
    check("up_ready_vec", lane_ready_o, 2'b01);
    check("up_pcs_rx", pcs_rx_rst_o, 2'b10);
    check("up_pcs_tx", pcs_tx_rst_o, 2'b10);
    check("up_pma1_low", pma_rstn_o[1], 1'b0);

    // TX with almost-full toggling.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      tx_valid_i[0]        = 1'b1;
      tx_data_i[7:0]       = 8'(8'h40 + i);
      phy_tx_afull_i       = {afull_pat[i], afull_pat[i]};
      if (!afull_pat[i]) tx_q.push_back(8'(8'h40 + i));
      @(negedge clk_i);
      check("tx0_ready", tx_ready_o[0], !afull_pat[i]);
    end
    @(posedge clk_i); #1;
    tx_valid_i[0]  = 1'b0;
    phy_tx_afull_i = '0;

    // RX from a non-empty FIFO.
    phy_rx_empty_i[0] = 1'b0;
    phy_rx_vld_i[0]   = 1'b1;
    phy_rx_data_i[7:0] = 8'hA5;
    rx_q.push_back(8'hA5);
    @(negedge clk_i);
    check("rx0_rden", phy_rx_rden_o[0], 1'b1);
    check("rx1_rden_gated", phy_rx_rden_o[1], 1'b0);
    @(posedge clk_i); #1;
    phy_rx_data_i[7:0] = 8'h3C;
    rx_q.push_back(8'h3C);
    @(posedge clk_i); #1;
    phy_rx_vld_i[0]    = 1'b0;
    phy_rx_empty_i[0]  = 1'b1;
    phy_rx_data_i[7:0] = 8'h00;
    @(negedge clk_i);
    check("rx0_rden_empty", phy_rx_rden_o[0], 1'b0);

    // CDR drop for 3 cycles in READY, with RX valid held high across the drop.
    tick(2);
    c = cyc;
    cdr_lock_i[0]      = 1'b0;
    phy_rx_vld_i[0]    = 1'b1;
    phy_rx_data_i[7:0] = 8'h11;
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h11);
    rdy_q.push_back('{1'b0, c + 3});
    rdy_q.push_back('{1'b1, c + 14});
    pma_q.push_back('{1'b0, c + 3});
    pma_q.push_back('{1'b1, c + 5});
    ret_q.push_back(4'd1);
    tick(3);
    cdr_lock_i[0]   = 1'b1;
    phy_rx_vld_i[0] = 1'b0;
    @(negedge clk_i);
    check("drop_pcs_rx", pcs_rx_rst_o[0], 1'b1);
    check("drop_pcs_tx", pcs_tx_rst_o[0], 1'b1);
    tick(13);

    // Second drop, then async reset while the lane is in PCS_SETTLE.
    c = cyc;
    cdr_lock_i[0] = 1'b0;
    rdy_q.push_back('{1'b0, c + 3});
    pma_q.push_back('{1'b0, c + 3});
    pma_q.push_back('{1'b1, c + 5});
    ret_q.push_back(4'd2);
    tick(3);
    cdr_lock_i[0] = 1'b1;
    tick(8);
    @(negedge clk_i);
    check("pcs_settle_pcs_rx", pcs_rx_rst_o[0], 1'b0);
    check("pcs_settle_ready", lane_ready_o[0], 1'b0);
    @(posedge clk_i); #1;
    edge_mon_en   = 1'b0;
    rst_i         = 1'b1;
    cdr_lock_i[0] = 1'b0;
    #1;
    check("arst_pma_rstn", pma_rstn_o, 2'b00);
    check("arst_pcs_rx", pcs_rx_rst_o, 2'b11);
    check("arst_pcs_tx", pcs_tx_rst_o, 2'b11);
    check("arst_ready", lane_ready_o, 2'b00);
    check("arst_retry", retry_cnt_o, 8'h00);
    check("arst_tx_ready", tx_ready_o, 2'b00);
    check("arst_rden", phy_rx_rden_o, 2'b00);
    check("arst_rx_valid", rx_valid_o, 2'b00);
    check("arst_rx_data", rx_data_o, 16'h0000);

    // CDR never locks: retry climbs to 15 and saturates there.
    for (int i = 1; i <= 15; i++) ret_q.push_back(4'(i));
    tick(2);
    rst_i = 1'b0;
    tick(400);
    @(negedge clk_i);
    check("retry0_saturated", retry_cnt_o[3:0], 4'd15);
    check("retry1_zero", retry_cnt_o[7:4], 4'd0);

    check("pending_rdy", rdy_q.size(), 0);
    check("pending_pma", pma_q.size(), 0);
    check("pending_tx", tx_q.size(), 0);
    check("pending_rx", rx_q.size(), 0);
    check("pending_retry", ret_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
